// File: rtl/cnn_pkg.sv
// Shared CNN-block definitions: scanner state encoding and a width helper.
package cnn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // ceil(log2(value)), never below 1 so single-entry ranges still get a bit
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/window_gather.sv
// Combinational K x K neighbourhood fetch from the flat frame bus, zero outside the frame.
module window_gather
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 256,
    parameter int K          = 3,
    localparam int RW        = clog2(HEIGHT),
    localparam int CW        = clog2(WIDTH)
) (
    input  logic [WIDTH*HEIGHT*DATA_WIDTH-1:0] frame_in,
    input  logic [RW-1:0]                      row,
    input  logic [CW-1:0]                      col,
    output logic [K*K*DATA_WIDTH-1:0]          win
);

    localparam int PAD = K / 2;
    localparam int IW  = clog2(WIDTH * HEIGHT * DATA_WIDTH);

    for (genvar i = 0; i < K; i++) begin : g_i
        for (genvar j = 0; j < K; j++) begin : g_j
            // Neighbour coordinates held as wide signed ints so that both
            // negative and past-the-edge positions are caught without wrap.
            int              rr;
            int              cc;
            logic            in_frame;
            logic [IW-1:0]   base;

            always_comb begin
                rr       = int'(row) + i - PAD;
                cc       = int'(col) + j - PAD;
                in_frame = (rr >= 0) && (rr < HEIGHT) && (cc >= 0) && (cc < WIDTH);
                base     = '0;
                if (in_frame) base = IW'((rr * WIDTH + cc) * DATA_WIDTH);
            end

            assign win[(i*K+j)*DATA_WIDTH +: DATA_WIDTH] =
                in_frame ? frame_in[base +: DATA_WIDTH] : '0;
        end
    end

endmodule

// File: rtl/window_scanner.sv
// Raster walk over a captured frame, emitting one padded K x K window per pixel on valid/ready.
module window_scanner
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 256,
    parameter int K          = 3,
    localparam int RW        = clog2(HEIGHT),
    localparam int CW        = clog2(WIDTH)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [WIDTH*HEIGHT*DATA_WIDTH-1:0] frame_in,
    input  logic                               frame_valid,
    output logic [K*K*DATA_WIDTH-1:0]          win_data,
    output logic [RW-1:0]                      win_row,
    output logic [CW-1:0]                      win_col,
    output logic                               win_valid,
    input  logic                               win_ready,
    output logic                               busy,
    output logic                               done
);

    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

    scan_state_t                  state;
    logic                         fv_prev;
    logic [RW-1:0]                g_row;
    logic [CW-1:0]                g_col;
    logic [K*K*DATA_WIDTH-1:0]    g_win;
    logic                         last_win;

    // Gather address: origin when starting, otherwise the raster successor.
    always_comb begin
        g_row = win_row;
        g_col = win_col + 1'b1;
        if (state == IDLE) begin
            g_row = '0;
            g_col = '0;
        end else if (win_col == LAST_COL) begin
            g_row = win_row + 1'b1;
            g_col = '0;
        end
    end

    assign last_win = (win_row == LAST_ROW) && (win_col == LAST_COL);

    window_gather #(
        .DATA_WIDTH (DATA_WIDTH),
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .K          (K)
    ) u_gather (
        .frame_in (frame_in),
        .row      (g_row),
        .col      (g_col),
        .win      (g_win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fv_prev   <= 1'b0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            win_data  <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            fv_prev <= frame_valid;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_valid && !fv_prev) begin
                        state     <= SCAN;
                        win_valid <= 1'b1;
                        busy      <= 1'b1;
                        win_data  <= g_win;
                        win_row   <= g_row;
                        win_col   <= g_col;
                    end
                end
                SCAN: begin
                    // Frame-valid edges are deliberately ignored here.
                    if (win_valid && win_ready) begin
                        if (last_win) begin
                            state     <= IDLE;
                            win_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            win_data <= g_win;
                            win_row  <= g_row;
                            win_col  <= g_col;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
